hamming74_decoder: RTL
======================

// Module: hamming74_decoder
// PURPOSE
//  Receive-side stage that sits directly downstream of the fault-injection channel.
//  Accepts one 7-bit Hamming(7,4) codeword per handshake and computes the 3-bit syndrome.
//  Corrects any single-bit error and delivers the 4-bit data word through a 2-stage pipeline.
//  Optional statistics counters measure the channel's effective error rate.
// PARAMETERS
//  CNT_W   16   width of statistics counters (DEC_STATS_EN only)
// PORTS
//  clk            in   1      single clock, rising edge
//  rst            in   1      asynchronous, active-low reset (assert 0 = reset)
//  code_in        in   7      received codeword
//  in_valid       in   1      code_in valid
//  in_ready       out  1      decoder can accept code_in this cycle
//  data_out       out  4      corrected data {d3,d2,d1,d0}
//  err_corrected  out  1      1 = nonzero syndrome, one bit was flipped back
//  syndrome       out  3      raw syndrome {s2,s1,s0}
//  out_valid      out  1      data_out/err_corrected/syndrome valid
//  out_ready      in   1      consumer accepts output
//  stats_clr      in   1      synchronous clear of counters
//  frames_total   out  CNT_W  codewords accepted
//  errors_fixed   out  CNT_W  codewords with nonzero syndrome
// BEHAVIOUR
//  - Bit map, position p = index+1: code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4,
//    code[4]=d1, code[5]=d2, code[6]=d3. Even parity.
//  - s0 = ^{p1,p3,p5,p7}; s1 = ^{p2,p3,p6,p7}; s2 = ^{p4,p5,p6,p7}.
//  - Syndrome S != 0: invert code[S-1], then extract data. S == 0: pass the data through.
//  - Pipeline: stage A registers code_in and valid_a. Stage B registers the corrected data,
//    syndrome, err_corrected and out_valid, all computed from stage A.
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational).
//    Both stages load only when adv = 1. An input is taken when in_valid && in_ready.
//  - Latency is 2 clk from an accepted input to out_valid, with no backpressure.
//  - Throughput is 1 word per clk.
//  - Backpressure (out_valid && !out_ready): both stages hold, and in_ready = 0.
//    Outputs stay stable until accepted; no word is dropped or duplicated.
//  - Bubbles: if in_valid = 0 when adv = 1, valid_a is cleared. The bubble propagates
//    through stage B, and out_valid drops for one cycle.
//  - Reset (async, any time, including mid-pipeline) clears all pipeline contents:
//    valid_a=0, out_valid=0, data_out=0, syndrome=0, err_corrected=0, counters=0.
//    Outputs are 0 from reset assertion until the first word emerges after deassertion.
//  - Double-bit errors are undetectable by design. They are miscorrected silently and
//    still flagged err_corrected=1.
// CONFIGURATION
//  - Macro DEC_STATS_EN. Defined: frames_total increments on each accepted input
//    (in_valid && in_ready). errors_fixed increments when stage B loads a valid word
//    with S != 0.
//  - Both counters saturate at all-ones, and stats_clr clears both.
//  - stats_clr has priority over a same-cycle increment: the result is 0.
//  - Macro not defined: no counter flops; frames_total and errors_fixed are tied to 0,
//    and stats_clr is ignored. Ports exist in both builds.
// TESTING
//  1. Reset, then drive code 0x55 (data 4'b1011) with out_ready=1.
//     Expected 2 clk later: data_out=4'hB, syndrome=0, err_corrected=0.
//  2. Drive code 0x45 (0x55 with code[4] flipped).
//     Expected: data_out=4'hB, syndrome=3'd5, err_corrected=1, errors_fixed=1.
//  3. Stream 0x00, 0x7F, 0x54 back-to-back with out_ready=1.
//     Expected: data 0x0, 0xF, 0xB on consecutive cycles; syndromes 0, 0, 1.
//  4. Hold out_ready=0 for 3 clk with 2 words in flight.
//     Expected: in_ready=0, outputs stable; on release, both words emerge in order, none lost.
//  5. Assert rst=0 mid-stream with 2 words in flight.
//     Expected: out_valid=0 and data_out=0 immediately (asynchronous), counters 0.
//     After release, the first new word appears 2 clk after acceptance.
//  6. (DEC_STATS_EN, CNT_W=4) Feed 17 erroneous words.
//     Expected: errors_fixed saturates at 4'hF. Then stats_clr=1 together with a valid
//     erroneous word gives errors_fixed=0.

Source files
------------

// File: rtl/hamming74_decoder.sv
// hamming74_decoder
//   Receive-side Hamming(7,4) decoder with single-error correction.
//   Two-stage pipeline:
//     stage A holds the raw codeword,
//     stage B holds the corrected data, syndrome and flags.
//   One global advance signal moves both stages together.
//   Optional statistics counters are enabled by defining the macro DEC_STATS_EN.
//   Without that macro, frames_total and errors_fixed read as 0 and stats_clr
//   has no effect.
//   Codeword bit map, position p = index + 1:
//     code[0]=p1, code[1]=p2, code[2]=d0, code[3]=p4,
//     code[4]=d1, code[5]=d2, code[6]=d3
module hamming74_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       code_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       data_out,
  output logic             err_corrected,
  output logic [2:0]       syndrome,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] frames_total,
  output logic [CNT_W-1:0] errors_fixed
);

  // Even-parity checks over the positions covered by each syndrome bit.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    logic s0;
    logic s1;
    logic s2;
    s0 = c[0] ^ c[2] ^ c[4] ^ c[6];
    s1 = c[1] ^ c[2] ^ c[5] ^ c[6];
    s2 = c[3] ^ c[4] ^ c[5] ^ c[6];
    return {s2, s1, s0};
  endfunction

  // A nonzero syndrome names the erroneous position; flip code[S-1] back.
  function automatic logic [6:0] correct_code(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] r;
    case (s)
      3'd0:    r = c;
      3'd1:    r = c ^ 7'b000_0001;
      3'd2:    r = c ^ 7'b000_0010;
      3'd3:    r = c ^ 7'b000_0100;
      3'd4:    r = c ^ 7'b000_1000;
      3'd5:    r = c ^ 7'b001_0000;
      3'd6:    r = c ^ 7'b010_0000;
      3'd7:    r = c ^ 7'b100_0000;
      default: r = c;
    endcase
    return r;
  endfunction

  // Data bits sit at positions 3, 5, 6 and 7.
  function automatic logic [3:0] extract_data(input logic [6:0] c);
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Pipeline state
  logic       valid_a_q;
  logic       valid_a_d;
  logic [6:0] code_a_q;
  logic [6:0] code_a_d;
  logic       out_valid_q;
  logic       out_valid_d;
  logic [3:0] data_q;
  logic [3:0] data_d;
  logic [2:0] syn_q;
  logic [2:0] syn_d;
  logic       err_q;
  logic       err_d;

  logic       adv_s;
  logic [2:0] syn_a_s;
  logic [3:0] data_a_s;

  // Both stages move only when the output slot is empty or being consumed.
  assign adv_s    = !out_valid_q || out_ready;
  assign in_ready = adv_s;

  // Decode of whatever currently sits in stage A.
  assign syn_a_s  = calc_syndrome(code_a_q);
  assign data_a_s = extract_data(correct_code(code_a_q, syn_a_s));

  // Stage A next state: capture the input on advance; a missing input becomes a bubble.
  always_comb begin
    valid_a_d = valid_a_q;
    code_a_d  = code_a_q;
    if (adv_s) begin
      valid_a_d = in_valid;
      if (in_valid) begin
        code_a_d = code_in;
      end else begin
        code_a_d = code_a_q;
      end
    end else begin
      valid_a_d = valid_a_q;
      code_a_d  = code_a_q;
    end
  end

  // Stage B next state: load the decoded word on advance.
  // Data fields are kept across bubbles so they stay 0 after reset until the first word.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    syn_d       = syn_q;
    err_d       = err_q;
    if (adv_s) begin
      out_valid_d = valid_a_q;
      if (valid_a_q) begin
        data_d = data_a_s;
        syn_d  = syn_a_s;
        err_d  = (syn_a_s != 3'd0);
      end else begin
        data_d = data_q;
        syn_d  = syn_q;
        err_d  = err_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; the asynchronous reset empties both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_a_q   <= 1'b0;
      code_a_q    <= 7'd0;
      out_valid_q <= 1'b0;
      data_q      <= 4'd0;
      syn_q       <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      valid_a_q   <= valid_a_d;
      code_a_q    <= code_a_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      syn_q       <= syn_d;
      err_q       <= err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign data_out      = data_q;
  assign syndrome      = syn_q;
  assign err_corrected = err_q;

`ifdef DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: an all-ones counter stays at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [CNT_W-1:0] frames_q;
  logic [CNT_W-1:0] frames_d;
  logic [CNT_W-1:0] errors_q;
  logic [CNT_W-1:0] errors_d;
  logic             accept_s;
  logic             load_err_s;

  assign accept_s   = in_valid && adv_s;
  assign load_err_s = adv_s && valid_a_q && (syn_a_s != 3'd0);

  // Counter next state: a clear wins over a same-cycle increment.
  always_comb begin
    frames_d = frames_q;
    errors_d = errors_q;
    if (stats_clr) begin
      frames_d = {CNT_W{1'b0}};
      errors_d = {CNT_W{1'b0}};
    end else begin
      frames_d = sat_inc(frames_q, accept_s);
      errors_d = sat_inc(errors_q, load_err_s);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_q <= {CNT_W{1'b0}};
      errors_q <= {CNT_W{1'b0}};
    end else begin
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  assign frames_total = frames_q;
  assign errors_fixed = errors_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign frames_total     = {CNT_W{1'b0}};
  assign errors_fixed     = {CNT_W{1'b0}};
`endif

endmodule
